// File: rtl/expu_pkg.sv
// -----------------------------------------------------------------------------
// expu_pkg
// Shared types and constants for the expu_row sequencing controller.
//   expu_ctrl_state_e : controller FSM state encoding
//   EXPU_CTRL_STALL_W : width of the optional backpressure stall counter
// -----------------------------------------------------------------------------
package expu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } expu_ctrl_state_e;

    localparam int unsigned EXPU_CTRL_STALL_W = 32;

endpackage : expu_pkg

// File: rtl/expu_ctrl_vpipe.sv
// -----------------------------------------------------------------------------
// expu_ctrl_vpipe
// Valid-bit shadow of the expu_row pipeline. It has the same register
// behaviour as the row: clear has priority, and the stages shift only on
// enable. With NUM_REGS = 0 the pipe is a wire and no flops are built.
//   clk_i   in  clock
//   rst_ni  in  asynchronous active-low reset
//   en_i    in  stage advance (mirrors row enable_i)
//   clear_i in  synchronous flush (mirrors row clear_i)
//   v_i     in  valid entering stage 0
//   v_o     out valid leaving the last stage
// -----------------------------------------------------------------------------
module expu_ctrl_vpipe #(
    parameter int unsigned NUM_REGS = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clear_i,
    input  logic v_i,
    output logic v_o
);

    generate
        if (NUM_REGS == 0) begin : g_comb
            assign v_o = v_i;
        end else begin : g_regs
            logic [NUM_REGS-1:0] r_pipe;

            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the value its predecessor held before the edge.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_pipe <= '0;
                end else if (clear_i) begin
                    r_pipe <= '0;
                end else if (en_i) begin
                    r_pipe[0] <= v_i;
                    for (int i = 1; i < int'(NUM_REGS); i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign v_o = r_pipe[NUM_REGS-1];
        end
    endgenerate

endmodule : expu_ctrl_vpipe

// File: rtl/expu_ctrl.sv
// -----------------------------------------------------------------------------
// expu_ctrl
// Control-only sequencer for one expu_row exponential lane. Operand and result
// data bypass this block; it gates the element handshake, drives the row's
// enable/clear and tracks validity through the row's NUM_REGS stages.
//
// Optional build macro: EXPU_CTRL_PERF_EN adds a saturating 32-bit counter of
// backpressure cycles on stall_cnt_o; without it stall_cnt_o is tied to 0.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous abort/flush (priority over all events)
//   start_i, len_i         job request and element count (sampled in IDLE)
//   busy_o, done_o         in RUN/DRAIN; one-cycle completion pulse
//   in_valid_i, in_ready_o operand handshake
//   out_valid_o, out_ready_i, out_last_o  result handshake and last marker
//   row_enable_o, row_clear_o            to the row's enable_i / clear_i
//   stall_cnt_o            backpressure stall cycles (optional)
// -----------------------------------------------------------------------------
module expu_ctrl
    import expu_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 1,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [LEN_WIDTH-1:0]         len_i,
    output logic                         busy_o,
    output logic                         done_o,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         out_last_o,
    output logic                         row_enable_o,
    output logic                         row_clear_o,
    output logic [EXPU_CTRL_STALL_W-1:0] stall_cnt_o
);

    expu_ctrl_state_e     r_state;
    logic [LEN_WIDTH-1:0] r_len_q;
    logic [LEN_WIDTH-1:0] r_in_cnt;
    logic [LEN_WIDTH-1:0] r_out_cnt;

    logic w_busy;
    logic w_adv;
    logic w_in_room;
    logic w_accept;
    logic w_in_last;
    logic w_out_valid;
    logic w_out_hs;
    logic w_out_is_last;
    logic w_start_acc;

    assign w_busy      = (r_state == RUN) || (r_state == DRAIN);
    assign w_in_room   = (r_state == RUN) && (r_in_cnt != r_len_q);
    assign w_start_acc = (r_state == IDLE) && start_i;

    // Global advance: the pipe moves unless a result is held by backpressure.
    assign w_adv = ~w_out_valid | out_ready_i;

    generate
        if (NUM_REGS == 0) begin : g_ready_comb
            // A zero-depth row delivers the result in the accept cycle, so
            // acceptance must depend on out_ready_i directly. Using out_ready_i
            // here instead of w_adv also keeps the ready/valid path acyclic.
            assign in_ready_o = w_in_room & out_ready_i;
        end else begin : g_ready_pipe
            assign in_ready_o = w_in_room & w_adv;
        end
    endgenerate

    assign w_accept     = in_valid_i & in_ready_o;
    assign row_enable_o = w_adv & w_busy;
    assign row_clear_o  = clear_i;

    expu_ctrl_vpipe #(
        .NUM_REGS (NUM_REGS)
    ) u_vpipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (row_enable_o),
        .clear_i (clear_i),
        .v_i     (w_accept),
        .v_o     (w_out_valid)
    );

    assign out_valid_o   = w_out_valid;
    assign w_out_hs      = w_out_valid & out_ready_i;
    assign w_in_last     = (r_in_cnt + LEN_WIDTH'(1)) == r_len_q;
    assign w_out_is_last = r_out_cnt == (r_len_q - LEN_WIDTH'(1));
    assign out_last_o    = w_out_valid & w_out_is_last;

    assign busy_o = w_busy;
    assign done_o = (r_state == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_len_q   <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (clear_i) begin
            r_state   <= IDLE;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_len_q   <= len_i;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_state   <= (len_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_in_cnt <= r_in_cnt + LEN_WIDTH'(1);
                    end
                    if (w_out_hs) begin
                        r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
                    end
                    // Only a zero-depth row can emit its last result while
                    // still in RUN; that case skips DRAIN entirely.
                    if (w_out_hs && w_out_is_last) begin
                        r_state <= DONE;
                    end else if (w_accept && w_in_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_out_hs) begin
                        r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
                        if (w_out_is_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef EXPU_CTRL_PERF_EN
    logic [EXPU_CTRL_STALL_W-1:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (clear_i || w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + EXPU_CTRL_STALL_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_start_acc;
    assign stall_cnt_o   = '0;
`endif

endmodule : expu_ctrl

// File: tb/tb_expu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_expu_ctrl
// Directed bench for expu_ctrl. Instance A uses NUM_REGS=2, instance B uses
// NUM_REGS=0. Each step drives inputs after a falling edge and checks the
// packed control vector {busy, done, in_ready, out_valid, out_last,
// row_enable, row_clear} against a hand-computed value before the next
// rising edge. Honours EXPU_CTRL_PERF_EN for the stall counter expectations.
// -----------------------------------------------------------------------------
module tb_expu_ctrl;

    logic clk;
    logic rst_n;

    logic        a_clear, a_start, a_in_valid, a_out_ready;
    logic [15:0] a_len;
    logic        a_busy, a_done, a_in_ready, a_out_valid, a_out_last;
    logic        a_row_enable, a_row_clear;
    logic [31:0] a_stall;

    logic        b_clear, b_start, b_in_valid, b_out_ready;
    logic [15:0] b_len;
    logic        b_busy, b_done, b_in_ready, b_out_valid, b_out_last;
    logic        b_row_enable, b_row_clear;
    logic [31:0] b_stall;

    int n_checks = 0;
    int n_pass   = 0;
    int a_hs     = 0;
    int a_lasts  = 0;
    int b_hs     = 0;

`ifdef EXPU_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    expu_ctrl #(.NUM_REGS(2), .LEN_WIDTH(16)) dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (a_clear),
        .start_i      (a_start),
        .len_i        (a_len),
        .busy_o       (a_busy),
        .done_o       (a_done),
        .in_valid_i   (a_in_valid),
        .in_ready_o   (a_in_ready),
        .out_valid_o  (a_out_valid),
        .out_ready_i  (a_out_ready),
        .out_last_o   (a_out_last),
        .row_enable_o (a_row_enable),
        .row_clear_o  (a_row_clear),
        .stall_cnt_o  (a_stall)
    );

    expu_ctrl #(.NUM_REGS(0), .LEN_WIDTH(16)) dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (b_clear),
        .start_i      (b_start),
        .len_i        (b_len),
        .busy_o       (b_busy),
        .done_o       (b_done),
        .in_valid_i   (b_in_valid),
        .in_ready_o   (b_in_ready),
        .out_valid_o  (b_out_valid),
        .out_ready_i  (b_out_ready),
        .out_last_o   (b_out_last),
        .row_enable_o (b_row_enable),
        .row_clear_o  (b_row_clear),
        .stall_cnt_o  (b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] vec_a();
        return {a_busy, a_done, a_in_ready, a_out_valid, a_out_last, a_row_enable, a_row_clear};
    endfunction

    function automatic logic [6:0] vec_b();
        return {b_busy, b_done, b_in_ready, b_out_valid, b_out_last, b_row_enable, b_row_clear};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One cycle on instance A: drive, settle, check, record handshakes.
    task automatic step_a(input string tag, input logic st, input logic [15:0] ln,
                          input logic iv, input logic ordy, input logic clr,
                          input logic [6:0] exp);
        logic [6:0] obs;
        @(negedge clk);
        a_start = st; a_len = ln; a_in_valid = iv; a_out_ready = ordy; a_clear = clr;
        #1;
        obs = vec_a();
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        if (a_out_valid && a_out_ready) begin
            a_hs++;
            if (a_out_last) a_lasts++;
        end
    endtask

    task automatic step_b(input string tag, input logic st, input logic [15:0] ln,
                          input logic iv, input logic ordy, input logic clr,
                          input logic [6:0] exp);
        logic [6:0] obs;
        @(negedge clk);
        b_start = st; b_len = ln; b_in_valid = iv; b_out_ready = ordy; b_clear = clr;
        #1;
        obs = vec_b();
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        if (b_out_valid && b_out_ready) b_hs++;
    endtask

    initial begin
        rst_n = 1'b0;
        a_clear = 0; a_start = 0; a_len = '0; a_in_valid = 0; a_out_ready = 1;
        b_clear = 0; b_start = 0; b_len = '0; b_in_valid = 0; b_out_ready = 1;
        #2;
        check("reset_a_vec", 32'(vec_a()), 32'h0);
        check("reset_b_vec", 32'(vec_b()), 32'h0);
        check("reset_a_stall", a_stall, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Job 1: NUM_REGS=2, len 4, no backpressure.
        a_hs = 0; a_lasts = 0;
        step_a("j1_c0", 1, 16'd4, 1, 1, 0, 7'b0000000);
        step_a("j1_c1", 0, 16'd0, 1, 1, 0, 7'b1010010);
        step_a("j1_c2", 0, 16'd0, 1, 1, 0, 7'b1010010);
        step_a("j1_c3", 0, 16'd0, 1, 1, 0, 7'b1011010);
        step_a("j1_c4", 0, 16'd0, 1, 1, 0, 7'b1011010);
        step_a("j1_c5", 0, 16'd0, 1, 1, 0, 7'b1001010);
        step_a("j1_c6", 0, 16'd0, 1, 1, 0, 7'b1001110);
        step_a("j1_c7", 0, 16'd0, 1, 1, 0, 7'b0100000);
        step_a("j1_c8", 0, 16'd0, 1, 1, 0, 7'b0000000);
        check("j1_handshakes", a_hs, 4);
        check("j1_lasts", a_lasts, 1);

        // Job 2: same job, out_ready low for three cycles mid-stream.
        a_hs = 0; a_lasts = 0;
        step_a("j2_c0",  1, 16'd4, 1, 1, 0, 7'b0000000);
        step_a("j2_c1",  0, 16'd0, 1, 1, 0, 7'b1010010);
        step_a("j2_c2",  0, 16'd0, 1, 1, 0, 7'b1010010);
        step_a("j2_c3",  0, 16'd0, 1, 1, 0, 7'b1011010);
        step_a("j2_c4",  0, 16'd0, 1, 0, 0, 7'b1001000);
        step_a("j2_c5",  0, 16'd0, 1, 0, 0, 7'b1001000);
        step_a("j2_c6",  0, 16'd0, 1, 0, 0, 7'b1001000);
        step_a("j2_c7",  0, 16'd0, 1, 1, 0, 7'b1011010);
        step_a("j2_c8",  0, 16'd0, 1, 1, 0, 7'b1001010);
        step_a("j2_c9",  0, 16'd0, 1, 1, 0, 7'b1001110);
        step_a("j2_c10", 0, 16'd0, 1, 1, 0, 7'b0100000);
        step_a("j2_c11", 0, 16'd0, 0, 1, 0, 7'b0000000);
        check("j2_handshakes", a_hs, 4);
        check("j2_lasts", a_lasts, 1);
        check("j2_stall", a_stall, PERF ? 32'd3 : 32'd0);

        // Job 3: zero-length job goes straight to DONE; in_valid is ignored.
        step_a("j3_c0", 1, 16'd0, 1, 1, 0, 7'b0000000);
        step_a("j3_c1", 0, 16'd0, 1, 1, 0, 7'b0100000);
        step_a("j3_c2", 0, 16'd0, 1, 1, 0, 7'b0000000);
        check("j3_stall_cleared", a_stall, 32'd0);

        // Job 4: clear in DRAIN with two results in flight.
        step_a("j4_c0", 1, 16'd2, 1, 1, 0, 7'b0000000);
        step_a("j4_c1", 0, 16'd0, 1, 1, 0, 7'b1010010);
        step_a("j4_c2", 0, 16'd0, 1, 1, 0, 7'b1010010);
        step_a("j4_c3", 0, 16'd0, 0, 1, 1, 7'b1001011);
        step_a("j4_c4", 0, 16'd0, 0, 1, 0, 7'b0000000);
        step_a("j4_c5", 0, 16'd0, 0, 1, 0, 7'b0000000);

        // Job 6: five backpressure cycles, then stall counter reset on start.
        step_a("j6_c0", 1, 16'd1, 0, 0, 0, 7'b0000000);
        step_a("j6_c1", 0, 16'd0, 1, 0, 0, 7'b1010010);
        step_a("j6_c2", 0, 16'd0, 0, 0, 0, 7'b1000010);
        step_a("j6_c3", 0, 16'd0, 0, 0, 0, 7'b1001100);
        step_a("j6_c4", 0, 16'd0, 0, 0, 0, 7'b1001100);
        step_a("j6_c5", 0, 16'd0, 0, 0, 0, 7'b1001100);
        step_a("j6_c6", 0, 16'd0, 0, 0, 0, 7'b1001100);
        step_a("j6_c7", 0, 16'd0, 0, 0, 0, 7'b1001100);
        step_a("j6_c8", 0, 16'd0, 0, 1, 0, 7'b1001110);
        step_a("j6_c9", 0, 16'd0, 0, 1, 0, 7'b0100000);
        check("j6_stall_done", a_stall, PERF ? 32'd5 : 32'd0);
        step_a("j6_c10", 1, 16'd1, 0, 1, 0, 7'b0000000);
        check("j6_stall_idle", a_stall, PERF ? 32'd5 : 32'd0);
        step_a("j6_c11", 0, 16'd0, 0, 1, 1, 7'b1010011);
        check("j6_stall_restart", a_stall, 32'd0);
        step_a("j6_c12", 0, 16'd0, 0, 1, 0, 7'b0000000);

        // Job 5: NUM_REGS=0, len 3, out_ready toggling 1,0,1,1.
        b_hs = 0;
        step_b("j5_c0", 1, 16'd3, 1, 1, 0, 7'b0000000);
        step_b("j5_c1", 0, 16'd0, 1, 1, 0, 7'b1011010);
        step_b("j5_c2", 0, 16'd0, 1, 0, 0, 7'b1000010);
        step_b("j5_c3", 0, 16'd0, 1, 1, 0, 7'b1011010);
        step_b("j5_c4", 0, 16'd0, 1, 1, 0, 7'b1011110);
        step_b("j5_c5", 0, 16'd0, 1, 1, 0, 7'b0100000);
        step_b("j5_c6", 0, 16'd0, 0, 1, 0, 7'b0000000);
        check("j5_handshakes", b_hs, 3);
        check("j5_stall", b_stall, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_expu_ctrl
